// File: rtl/cluster_apu_pkg.sv
// rtl/cluster_apu_pkg.sv - shared widths, payload structs and width helpers for the APU slice
package cluster_apu_pkg;

  localparam int WAPUTYPE_DEF = 3;
  localparam int NARGS_DEF    = 2;
  localparam int WOP_DEF      = 1;
  localparam int NDS_DEF      = 3;
  localparam int NUS_DEF      = 5;

  typedef struct packed {
    logic [WAPUTYPE_DEF-1:0]     apu_type;
    logic [NARGS_DEF-1:0][31:0]  operands;
    logic [WOP_DEF-1:0]          op;
    logic [NDS_DEF-1:0]          flags;
  } req_t;

  typedef struct packed {
    logic [31:0]        result;
    logic [NUS_DEF-1:0] flags;
  } resp_t;

  function automatic int req_width(input int wtype, input int nargs, input int wop, input int nds);
    return wtype + nargs * 32 + wop + nds;
  endfunction

  function automatic int resp_width(input int nus);
    return 32 + nus;
  endfunction

endpackage

// File: rtl/cluster_apu_fifo.sv
// rtl/cluster_apu_fifo.sv - generic register FIFO with full/empty flags
// Head data comes straight from the storage registers, so it is stable until popped.
module cluster_apu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = (wr_q == LAST) ? '0 : wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cluster_apu_slice.sv
// rtl/cluster_apu_slice.sv - per-core elastic APU slice: request/response buffering and outstanding limit
module cluster_apu_slice
  import cluster_apu_pkg::*;
#(
  parameter int WAPUTYPE         = WAPUTYPE_DEF,
  parameter int APU_NARGS_CPU    = NARGS_DEF,
  parameter int APU_WOP_CPU      = WOP_DEF,
  parameter int APU_NDSFLAGS_CPU = NDS_DEF,
  parameter int APU_NUSFLAGS_CPU = NUS_DEF,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int REQ_DEPTH        = 2,
  parameter int RESP_DEPTH       = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           slv_req_i,
  output logic                           slv_gnt_o,
  input  logic [WAPUTYPE-1:0]            slv_type_i,
  input  logic [APU_NARGS_CPU-1:0][31:0] slv_operands_i,
  input  logic [APU_WOP_CPU-1:0]         slv_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]    slv_flags_i,
  input  logic                           slv_ready_i,
  output logic                           slv_valid_o,
  output logic [31:0]                    slv_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]    slv_flags_o,
  output logic                           mst_req_o,
  input  logic                           mst_gnt_i,
  output logic [WAPUTYPE-1:0]            mst_type_o,
  output logic [APU_NARGS_CPU-1:0][31:0] mst_operands_o,
  output logic [APU_WOP_CPU-1:0]         mst_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]    mst_flags_o,
  output logic                           mst_ready_o,
  input  logic                           mst_valid_i,
  input  logic [31:0]                    mst_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]    mst_flags_i,
  output logic                           perf_stall_o
);

  localparam int REQ_W  = req_width(WAPUTYPE, APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU);
  localparam int RESP_W = resp_width(APU_NUSFLAGS_CPU);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  if (RESP_DEPTH < MAX_OUTSTANDING) begin : g_depth_check
    $error("RESP_DEPTH must be >= MAX_OUTSTANDING");
  end

  logic              req_full, req_empty, resp_full, resp_empty;
  logic [REQ_W-1:0]  req_head;
  logic [RESP_W-1:0] resp_head;
  logic              req_push, issue, resp_push, resp_pop;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              perf_stall_q, perf_stall_d;

  // Every handshake output is forced low while reset is held.
  assign slv_gnt_o    = ~rst_i & ~req_full;
  assign mst_ready_o  = ~rst_i & ~resp_full;
  assign mst_req_o    = ~rst_i & ~req_empty & (out_cnt_q < CNT_MAX);
  assign slv_valid_o  = ~rst_i & ~resp_empty;
  assign perf_stall_o = ~rst_i & perf_stall_q;

  assign req_push  = slv_req_i & slv_gnt_o;
  assign issue     = mst_req_o & mst_gnt_i;
  assign resp_push = mst_valid_i & mst_ready_o & (out_cnt_q != '0);
  assign resp_pop  = slv_valid_o & slv_ready_i;

  cluster_apu_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_push),
    .data_i  ({slv_type_i, slv_operands_i, slv_op_i, slv_flags_i}),
    .pop_i   (issue),
    .data_o  (req_head),
    .full_o  (req_full),
    .empty_o (req_empty)
  );

  cluster_apu_fifo #(.WIDTH(RESP_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (resp_push),
    .data_i  ({mst_result_i, mst_flags_i}),
    .pop_i   (resp_pop),
    .data_o  (resp_head),
    .full_o  (resp_full),
    .empty_o (resp_empty)
  );

  assign {mst_type_o, mst_operands_o, mst_op_o, mst_flags_o} = req_head;
  assign {slv_result_o, slv_flags_o} = resp_head;

  always_comb begin
    out_cnt_d    = out_cnt_q;
    perf_stall_d = slv_req_i & ~slv_gnt_o;
    case ({issue, resp_pop})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q    <= '0;
      perf_stall_q <= 1'b0;
    end else begin
      out_cnt_q    <= out_cnt_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  a_no_resp_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    mst_valid_i |-> ~resp_full);
  a_no_orphan_resp : assert property (@(posedge clk_i) disable iff (rst_i)
    mst_valid_i |-> (out_cnt_q != '0));
  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    out_cnt_q <= CNT_MAX);

endmodule

// File: tb/tb_cluster_apu_slice.sv
// tb/tb_cluster_apu_slice.sv - directed self-checking bench for cluster_apu_slice
module tb_cluster_apu_slice;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             slv_req_i, slv_gnt_o, slv_ready_i, slv_valid_o;
  logic [2:0]       slv_type_i;
  logic [1:0][31:0] slv_operands_i;
  logic [0:0]       slv_op_i;
  logic [2:0]       slv_flags_i;
  logic [31:0]      slv_result_o;
  logic [4:0]       slv_flags_o;
  logic             mst_req_o, mst_gnt_i, mst_ready_o, mst_valid_i;
  logic [2:0]       mst_type_o;
  logic [1:0][31:0] mst_operands_o;
  logic [0:0]       mst_op_o;
  logic [2:0]       mst_flags_o;
  logic [31:0]      mst_result_i;
  logic [4:0]       mst_flags_i;
  logic             perf_stall_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cluster_apu_slice dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .slv_req_i      (slv_req_i),
    .slv_gnt_o      (slv_gnt_o),
    .slv_type_i     (slv_type_i),
    .slv_operands_i (slv_operands_i),
    .slv_op_i       (slv_op_i),
    .slv_flags_i    (slv_flags_i),
    .slv_ready_i    (slv_ready_i),
    .slv_valid_o    (slv_valid_o),
    .slv_result_o   (slv_result_o),
    .slv_flags_o    (slv_flags_o),
    .mst_req_o      (mst_req_o),
    .mst_gnt_i      (mst_gnt_i),
    .mst_type_o     (mst_type_o),
    .mst_operands_o (mst_operands_o),
    .mst_op_o       (mst_op_o),
    .mst_flags_o    (mst_flags_o),
    .mst_ready_o    (mst_ready_o),
    .mst_valid_i    (mst_valid_i),
    .mst_result_i   (mst_result_i),
    .mst_flags_i    (mst_flags_i),
    .perf_stall_o   (perf_stall_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] op0);
    slv_req_i         = 1'b1;
    slv_type_i        = 3'd2;
    slv_operands_i[0] = op0;
    slv_operands_i[1] = op0 + 32'd1;
    slv_op_i          = 1'b0;
    slv_flags_i       = 3'd1;
  endtask

  task automatic drive_resp(input logic [31:0] res);
    mst_valid_i  = 1'b1;
    mst_result_i = res;
    mst_flags_i  = res[4:0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; slv_req_i = 1'b0; slv_type_i = '0; slv_operands_i = '0;
    slv_op_i = '0; slv_flags_i = '0; slv_ready_i = 1'b1; mst_gnt_i = 1'b0;
    mst_valid_i = 1'b0; mst_result_i = '0; mst_flags_i = '0;

    // reset state
    tick; tick;
    check("rst_gnt", slv_gnt_o, 0);
    check("rst_ready", mst_ready_o, 0);
    check("rst_req", mst_req_o, 0);
    check("rst_valid", slv_valid_o, 0);
    check("rst_stall", perf_stall_o, 0);
    rst_i = 1'b0;
    #1;
    check("rel_gnt", slv_gnt_o, 1);
    check("rel_ready", mst_ready_o, 1);

    // single op
    tick;
    slv_req_i = 1'b1; slv_type_i = 3'd5; slv_op_i = 1'b1; slv_flags_i = 3'd6;
    slv_operands_i[0] = 32'h3F80_0000; slv_operands_i[1] = 32'h4000_0000;
    tick;
    slv_req_i = 1'b0;
    check("t1_req", mst_req_o, 1);
    check("t1_op0", mst_operands_o[0], 32'h3F80_0000);
    check("t1_op1", mst_operands_o[1], 32'h4000_0000);
    check("t1_type", mst_type_o, 5);
    check("t1_flags", mst_flags_o, 6);
    mst_gnt_i = 1'b1;
    tick;
    mst_gnt_i = 1'b0;
    check("t1_req_after_issue", mst_req_o, 0);
    check("t1_cnt1", dut.out_cnt_q, 1);
    tick; tick; tick;
    mst_valid_i = 1'b1; mst_result_i = 32'h4040_0000; mst_flags_i = 5'h11;
    tick;
    mst_valid_i = 1'b0;
    check("t1_valid", slv_valid_o, 1);
    check("t1_result", slv_result_o, 32'h4040_0000);
    check("t1_rflags", slv_flags_o, 5'h11);
    tick;
    check("t1_valid_gone", slv_valid_o, 0);
    check("t1_cnt0", dut.out_cnt_q, 0);

    // grant backpressure
    tick; drive_req(32'h100); check("t2_gnt_a", slv_gnt_o, 1);
    tick; drive_req(32'h101); check("t2_gnt_b", slv_gnt_o, 1);
    tick; drive_req(32'h102); check("t2_gnt_full", slv_gnt_o, 0);
    check("t2_stall_early", perf_stall_o, 0);
    tick;
    check("t2_stall_a", perf_stall_o, 1);
    check("t2_head_stable_a", mst_operands_o[0], 32'h100);
    check("t2_req_held", mst_req_o, 1);
    tick;
    check("t2_stall_b", perf_stall_o, 1);
    check("t2_head_stable_b", mst_operands_o[0], 32'h100);
    mst_gnt_i = 1'b1;
    tick;
    check("t2_gnt_back", slv_gnt_o, 1);
    check("t2_stall_c", perf_stall_o, 1);
    check("t2_head_p1", mst_operands_o[0], 32'h101);
    tick;
    slv_req_i = 1'b0;
    check("t2_stall_off", perf_stall_o, 0);
    check("t2_occ_const", slv_gnt_o, 1);
    check("t2_limit", mst_req_o, 0);
    check("t2_head_p2", mst_operands_o[0], 32'h102);
    check("t2_cnt2", dut.out_cnt_q, 2);
    drive_resp(32'h11);
    tick;
    check("t2_res11", slv_result_o, 32'h11);
    drive_resp(32'h22);
    tick;
    mst_valid_i = 1'b0;
    check("t2_res22", slv_result_o, 32'h22);
    check("t2_req_resume", mst_req_o, 1);
    check("t2_head_p2b", mst_operands_o[0], 32'h102);
    tick;
    check("t2_drained", mst_req_o, 0);
    check("t2_cnt1", dut.out_cnt_q, 1);
    mst_gnt_i = 1'b0;
    drive_resp(32'h33);
    tick;
    mst_valid_i = 1'b0;
    check("t2_res33", slv_result_o, 32'h33);
    tick;
    check("t2_cnt0", dut.out_cnt_q, 0);

    // outstanding limit, core backpressure, simultaneous issue/pop
    mst_gnt_i = 1'b1;
    tick; drive_req(32'h200);
    tick; drive_req(32'h201);
    check("t3_head0", mst_operands_o[0], 32'h200);
    tick; drive_req(32'h202);
    check("t3_head1", mst_operands_o[0], 32'h201);
    tick;
    slv_req_i = 1'b0;
    check("t3_limit", mst_req_o, 0);
    check("t3_cnt2", dut.out_cnt_q, 2);
    slv_ready_i = 1'b0;
    drive_resp(32'hA);
    tick;
    drive_resp(32'hB);
    check("t4_ready_a", mst_ready_o, 1);
    check("t4_res_a", slv_result_o, 32'hA);
    tick;
    mst_valid_i = 1'b0;
    check("t4_ready_full", mst_ready_o, 0);
    check("t4_res_hold", slv_result_o, 32'hA);
    check("t4_limit", mst_req_o, 0);
    slv_ready_i = 1'b1;
    tick;
    check("t4_res_b", slv_result_o, 32'hB);
    check("t4_req_after_pop", mst_req_o, 1);
    check("t4_cnt1", dut.out_cnt_q, 1);
    tick;
    check("t5_cnt_same", dut.out_cnt_q, 1);
    check("t5_valid_off", slv_valid_o, 0);
    check("t5_req_off", mst_req_o, 0);
    drive_resp(32'hC);
    tick;
    mst_valid_i = 1'b0;
    check("t5_res_c", slv_result_o, 32'hC);
    tick;
    check("t5_cnt0", dut.out_cnt_q, 0);

    // reset mid-operation
    tick; drive_req(32'h300);
    tick; drive_req(32'h301);
    tick; drive_req(32'h302);
    tick;
    slv_req_i = 1'b0;
    check("t6_cnt2", dut.out_cnt_q, 2);
    rst_i = 1'b1;
    #1;
    check("t6_rst_gnt", slv_gnt_o, 0);
    check("t6_rst_req", mst_req_o, 0);
    check("t6_rst_ready", mst_ready_o, 0);
    tick;
    check("t6_rst_valid", slv_valid_o, 0);
    check("t6_rst_cnt", dut.out_cnt_q, 0);
    rst_i = 1'b0;
    mst_gnt_i = 1'b0;
    #1;
    check("t6_rel_gnt", slv_gnt_o, 1);
    check("t6_rel_req", mst_req_o, 0);
    tick;
    check("t6_discarded", mst_req_o, 0);
    check("t6_cnt0", dut.out_cnt_q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
